control_fetch: RTL

CONTROL_FETCH -- requirements
Module: control_fetch

---
 rtl/control_fetch.sv | 110 +++++++++++
 1 files changed

// File: rtl/control_fetch.sv
// Control/fetch sequencer: IDLE -> LOAD -> FILL -> RUN, forwards ROM words.
// Ports: clk, rst, start, alg_sel, instruccion in; sel_dir, sel_pc, instr_out,
// instr_valid, busy, done, instr_count, wd_error out.
// Optional watchdog enabled by defining CTRL_WATCHDOG_EN.
module control_fetch #(
  parameter logic [3:0] END_OPCODE = 4'hF,
  parameter logic [9:0] WD_LIMIT   = 10'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  alg_sel,
  input  logic [13:0] instruccion,
  output logic [2:0]  sel_dir,
  output logic        sel_pc,
  output logic [13:0] instr_out,
  output logic        instr_valid,
  output logic        busy,
  output logic        done,
  output logic [9:0]  instr_count,
  output logic        wd_error
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILL,
    RUN
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  dir_q, dir_nxt;
  logic [9:0]  cnt_q, cnt_nxt;
  logic        wd_q, wd_nxt;
  logic        is_end;
  logic        wd_trip;

  assign is_end = (instruccion[13:10] == END_OPCODE);

`ifdef CTRL_WATCHDOG_EN
  assign wd_trip = (cnt_q == WD_LIMIT) && !is_end;
`else
  logic unused_wd;
  assign unused_wd = ^WD_LIMIT;
  assign wd_trip   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dir_q <= 3'd0;
      cnt_q <= 10'd0;
      wd_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      dir_q <= dir_nxt;
      cnt_q <= cnt_nxt;
      wd_q  <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dir_nxt     = dir_q;
    cnt_nxt     = cnt_q;
    wd_nxt      = wd_q;
    sel_pc      = 1'b0;
    instr_valid = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          dir_nxt   = alg_sel;
          cnt_nxt   = 10'd0;
          wd_nxt    = 1'b0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        sel_pc    = 1'b1;
        state_nxt = FILL;
      end
      FILL: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (is_end) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (wd_trip) begin
          wd_nxt    = 1'b1;
          state_nxt = IDLE;
        end else begin
          instr_valid = 1'b1;
          if (cnt_q != 10'h3FF) begin
            cnt_nxt = cnt_q + 10'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_dir     = dir_q;
  assign instr_out   = instruccion;
  assign busy        = (state != IDLE);
  assign instr_count = cnt_q;
  assign wd_error    = wd_q;

endmodule
